// File: rtl/axi_read_arbiter_pkg.sv
// +--------------------------------------------------------------------------+
// | axi_xbar_pkg                                                             |
// | Shared crossbar sizing, idle index constants, read address map, FSM enum |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

package axi_xbar_pkg;

  localparam int NUM_M     = 3;
  localparam int NUM_S     = 6;
  localparam int MIDX_BITS = 2;
  localparam int SIDX_BITS = 3;

  localparam logic [MIDX_BITS-1:0] IDLE_M = MIDX_BITS'(NUM_M);
  localparam logic [SIDX_BITS-1:0] IDLE_S = SIDX_BITS'(NUM_S + 1);

  // Slot 0 is the decode-error slave and has no range of its own.
  localparam logic [31:0] ADDR_BASE [1:NUM_S] = '{
    32'h0000_0000, 32'h0001_0000, 32'h0002_0000,
    32'h1000_0000, 32'h1001_0000, 32'h2000_0000
  };
  localparam logic [31:0] ADDR_LIMIT [1:NUM_S] = '{
    32'h0000_FFFF, 32'h0001_FFFF, 32'h0002_FFFF,
    32'h1000_03FF, 32'h1001_03FF, 32'h201F_FFFF
  };

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } arb_state_e;

  function automatic logic [SIDX_BITS-1:0] addr_decode(input logic [31:0] addr);
    logic [SIDX_BITS-1:0] slot;
    slot = '0;
    for (int s = 1; s <= NUM_S; s++) begin
      if (addr >= ADDR_BASE[s] && addr <= ADDR_LIMIT[s]) begin
        slot = SIDX_BITS'(s);
      end
    end
    return slot;
  endfunction

endpackage

`default_nettype wire

// File: rtl/axi_read_arbiter_rr_pick.sv
// +--------------------------------------------------------------------------+
// | axi_rr_pick                                                              |
// | Picks the first requester at or after a start pointer (one-hot + index)  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module axi_rr_pick #(
  parameter int N     = 3,
  parameter int PTR_W = 2
) (
  input  logic [N-1:0]     i_req,
  input  logic [PTR_W-1:0] i_ptr,
  output logic [N-1:0]     o_gnt,
  output logic             o_valid,
  output logic [PTR_W-1:0] o_idx
);

  always_comb begin : b_pick
    logic [PTR_W-1:0] w_idx;
    logic             w_found;
    o_gnt   = '0;
    o_idx   = '0;
    w_found = 1'b0;
    w_idx   = '0;
    for (int i = 0; i < N; i++) begin
      w_idx = PTR_W'((int'(i_ptr) + i) % N);
      if (!w_found && i_req[w_idx]) begin
        o_gnt[w_idx] = 1'b1;
        o_idx        = w_idx;
        w_found      = 1'b1;
      end
    end
    o_valid = w_found;
  end

endmodule

`default_nettype wire

// File: rtl/axi_read_arbiter.sv
// +--------------------------------------------------------------------------+
// | axi_read_arbiter                                                         |
// | Per-slave read arbitration with registered SRIdx/MRIdx routing indices.  |
// | AXI_ARB_RR_EN: round-robin per slave (default: lowest master index wins) |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module axi_read_arbiter #(
  parameter int NUM_M     = axi_xbar_pkg::NUM_M,
  parameter int NUM_S     = axi_xbar_pkg::NUM_S,
  parameter int MIDX_BITS = axi_xbar_pkg::MIDX_BITS,
  parameter int SIDX_BITS = axi_xbar_pkg::SIDX_BITS
) (
  input  logic                            ACLK,
  input  logic                            ARESET,
  input  logic [NUM_M-1:0]                ARVALID_M,
  input  logic [NUM_M-1:0][31:0]          ARADDR_M,
  input  logic [NUM_M-1:0]                RREADY_M,
  input  logic [NUM_S:0]                  ARREADY_S,
  input  logic [NUM_S:0]                  RVALID_S,
  input  logic [NUM_S:0]                  RLAST_S,
  output logic [NUM_S:0][MIDX_BITS-1:0]   SRIdx,
  output logic [NUM_M-1:0][SIDX_BITS-1:0] MRIdx
);

  import axi_xbar_pkg::arb_state_e;
  import axi_xbar_pkg::IDLE;
  import axi_xbar_pkg::ADDR;
  import axi_xbar_pkg::DATA;
  import axi_xbar_pkg::addr_decode;

  localparam logic [MIDX_BITS-1:0] C_M_IDLE = MIDX_BITS'(NUM_M);
  localparam logic [SIDX_BITS-1:0] C_S_IDLE = SIDX_BITS'(NUM_S + 1);

  logic [NUM_M-1:0][SIDX_BITS-1:0] w_dec;
  logic [NUM_M-1:0]                w_free;
  logic [NUM_S:0]                  w_grant;
  logic [NUM_S:0]                  w_rel;
  logic [NUM_S:0][NUM_M-1:0]       w_oh;

  for (genvar s = 0; s <= NUM_S; s++) begin : g_slave
    arb_state_e            r_state;
    arb_state_e            w_state_nxt;
    logic [MIDX_BITS-1:0]  r_sridx;
    logic [MIDX_BITS-1:0]  w_ptr;
    logic [MIDX_BITS-1:0]  w_win;
    logic [NUM_M-1:0]      w_req;
    logic [NUM_M-1:0]      w_sel;
    logic [NUM_M-1:0]      w_onehot;
    logic                  w_any;
    logic                  w_grant_l;
    logic                  w_rel_l;
    logic                  w_arvalid_b;
    logic                  w_rready_b;

    for (genvar m = 0; m < NUM_M; m++) begin : g_req
      assign w_req[m] = ARVALID_M[m] & w_free[m] & (w_dec[m] == SIDX_BITS'(s)) & (r_state == IDLE);
      assign w_sel[m] = (r_sridx == MIDX_BITS'(m));
    end

    // Handshake qualifiers come from whichever master is bound to this slot.
    assign w_arvalid_b = |(ARVALID_M & w_sel);
    assign w_rready_b  = |(RREADY_M & w_sel);

    axi_rr_pick #(
      .N     (NUM_M),
      .PTR_W (MIDX_BITS)
    ) u_pick (
      .i_req   (w_req),
      .i_ptr   (w_ptr),
      .o_gnt   (w_onehot),
      .o_valid (w_any),
      .o_idx   (w_win)
    );

    always_comb begin
      w_state_nxt = r_state;
      w_grant_l   = 1'b0;
      w_rel_l     = 1'b0;
      case (r_state)
        IDLE: begin
          if (w_any) begin
            w_grant_l   = 1'b1;
            w_state_nxt = ADDR;
          end
        end
        ADDR: begin
          if (w_arvalid_b && ARREADY_S[s]) w_state_nxt = DATA;
        end
        DATA: begin
          if (RVALID_S[s] && w_rready_b && RLAST_S[s]) begin
            w_rel_l     = 1'b1;
            w_state_nxt = IDLE;
          end
        end
        default: w_state_nxt = IDLE;
      endcase
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
        r_state <= IDLE;
        r_sridx <= C_M_IDLE;
      end else begin
        r_state <= w_state_nxt;
        if (w_grant_l)    r_sridx <= w_win;
        else if (w_rel_l) r_sridx <= C_M_IDLE;
      end
    end

`ifdef AXI_ARB_RR_EN
    logic [MIDX_BITS-1:0] r_ptr;

    always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
        r_ptr <= '0;
      end else if (w_grant_l) begin
        r_ptr <= (w_win == MIDX_BITS'(NUM_M - 1)) ? '0 : w_win + 1'b1;
      end
    end

    assign w_ptr = r_ptr;
`else
    assign w_ptr = '0;
`endif

    assign SRIdx[s]   = r_sridx;
    assign w_grant[s] = w_grant_l;
    assign w_rel[s]   = w_rel_l;
    assign w_oh[s]    = w_onehot;
  end

  for (genvar m = 0; m < NUM_M; m++) begin : g_master
    logic [SIDX_BITS-1:0] r_mridx;
    logic                 w_gnt_m;
    logic                 w_rel_m;

    assign w_dec[m]  = addr_decode(ARADDR_M[m]);
    assign w_free[m] = (r_mridx == C_S_IDLE);

    // A master can only be won by the slave it decodes to, and only
    // released by the slave it is currently bound to.
    assign w_gnt_m = w_grant[w_dec[m]] & w_oh[w_dec[m]][m];
    assign w_rel_m = (r_mridx != C_S_IDLE) & w_rel[r_mridx];

    always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
        r_mridx <= C_S_IDLE;
      end else if (w_gnt_m) begin
        r_mridx <= w_dec[m];
      end else if (w_rel_m) begin
        r_mridx <= C_S_IDLE;
      end
    end

    assign MRIdx[m] = r_mridx;
  end

endmodule

`default_nettype wire

// File: tb/tb_axi_read_arbiter.sv
// +--------------------------------------------------------------------------+
// | tb_axi_read_arbiter                                                      |
// | Vector table + scoreboard bench for axi_read_arbiter                     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_axi_read_arbiter;

  logic             ACLK = 1'b0;
  logic             ARESET;
  logic [2:0]       ARVALID_M;
  logic [2:0][31:0] ARADDR_M;
  logic [2:0]       RREADY_M;
  logic [6:0]       ARREADY_S;
  logic [6:0]       RVALID_S;
  logic [6:0]       RLAST_S;
  logic [6:0][1:0]  SRIdx;
  logic [2:0][2:0]  MRIdx;

  axi_read_arbiter u_dut (
    .ACLK      (ACLK),
    .ARESET    (ARESET),
    .ARVALID_M (ARVALID_M),
    .ARADDR_M  (ARADDR_M),
    .RREADY_M  (RREADY_M),
    .ARREADY_S (ARREADY_S),
    .RVALID_S  (RVALID_S),
    .RLAST_S   (RLAST_S),
    .SRIdx     (SRIdx),
    .MRIdx     (MRIdx)
  );

  always #5 ACLK = ~ACLK;

`ifdef AXI_ARB_RR_EN
  localparam int C_R2_WIN = 1;
`else
  localparam int C_R2_WIN = 0;
`endif

  localparam logic [13:0] C_SR_IDLE = {7{2'd3}};
  localparam logic [8:0]  C_MR_IDLE = {3{3'd7}};

  // Inputs for one cycle and up to two expected bindings (slot -1 = none).
  typedef struct {
    logic [2:0]  arvalid;
    logic [31:0] a0, a1, a2;
    logic [2:0]  rready;
    logic [6:0]  arready, rvalid, rlast;
    int          s0, m0, s1, m1;
    string       name;
  } vec_t;

  typedef struct {
    logic [13:0] sr;
    logic [8:0]  mr;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  vec_t tbl[22];
  vec_t v;

  function automatic vec_t mk(logic [2:0] arvalid, logic [31:0] a0, logic [31:0] a1,
                              logic [31:0] a2, logic [2:0] rready, logic [6:0] arready,
                              logic [6:0] rvalid, logic [6:0] rlast, int s0, int m0,
                              int s1, int m1, string name);
    vec_t r;
    r.arvalid = arvalid; r.a0 = a0; r.a1 = a1; r.a2 = a2;
    r.rready = rready; r.arready = arready; r.rvalid = rvalid; r.rlast = rlast;
    r.s0 = s0; r.m0 = m0; r.s1 = s1; r.m1 = m1; r.name = name;
    return r;
  endfunction

  function automatic exp_t expect_of(vec_t x);
    exp_t             e;
    logic [6:0][1:0]  sr;
    logic [2:0][2:0]  mr;
    sr = C_SR_IDLE;
    mr = C_MR_IDLE;
    if (x.s0 >= 0) begin sr[x.s0] = 2'(x.m0); mr[x.m0] = 3'(x.s0); end
    if (x.s1 >= 0) begin sr[x.s1] = 2'(x.m1); mr[x.m1] = 3'(x.s1); end
    e.sr = sr; e.mr = mr; e.name = x.name;
    return e;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic apply(vec_t x);
    exp_t e;
    ARVALID_M = x.arvalid;
    ARADDR_M  = {x.a2, x.a1, x.a0};
    RREADY_M  = x.rready;
    ARREADY_S = x.arready;
    RVALID_S  = x.rvalid;
    RLAST_S   = x.rlast;
    sb.push_back(expect_of(x));
    @(posedge ACLK);
    #1;
    e = sb.pop_front();
    check({e.name, " SRIdx"}, 32'(SRIdx), 32'(e.sr));
    check({e.name, " MRIdx"}, 32'(MRIdx), 32'(e.mr));
  endtask

  initial begin
    // Single read to S2, 4 beats.
    tbl[0]  = mk(3'b001, 32'h0001_0040, 0, 0, 3'b000, 7'h00, 7'h00, 7'h00, 2, 0, -1, 0, "single grant");
    tbl[1]  = mk(3'b001, 32'h0001_0040, 0, 0, 3'b000, 7'h04, 7'h00, 7'h00, 2, 0, -1, 0, "single ar");
    tbl[2]  = mk(3'b000, 0, 0, 0, 3'b001, 7'h00, 7'h04, 7'h00, 2, 0, -1, 0, "single beat1");
    tbl[3]  = mk(3'b000, 0, 0, 0, 3'b001, 7'h00, 7'h04, 7'h00, 2, 0, -1, 0, "single beat2");
    tbl[4]  = mk(3'b000, 0, 0, 0, 3'b001, 7'h00, 7'h04, 7'h00, 2, 0, -1, 0, "single beat3");
    tbl[5]  = mk(3'b000, 0, 0, 0, 3'b001, 7'h00, 7'h04, 7'h04, -1, 0, -1, 0, "single last");
    // Parallel M0->S1, M1->S2; S1 completes first.
    tbl[6]  = mk(3'b011, 32'h0000_0100, 32'h0001_0000, 0, 3'b000, 7'h00, 7'h00, 7'h00, 1, 0, 2, 1, "par grant");
    tbl[7]  = mk(3'b011, 32'h0000_0100, 32'h0001_0000, 0, 3'b000, 7'h06, 7'h00, 7'h00, 1, 0, 2, 1, "par ar");
    tbl[8]  = mk(3'b000, 0, 0, 0, 3'b011, 7'h00, 7'h06, 7'h02, 2, 1, -1, 0, "par s1 last");
    tbl[9]  = mk(3'b000, 0, 0, 0, 3'b011, 7'h00, 7'h04, 7'h04, -1, 0, -1, 0, "par s2 last");
    // Decode error to slot 0.
    tbl[10] = mk(3'b100, 0, 0, 32'h3000_0000, 3'b000, 7'h00, 7'h00, 7'h00, 0, 2, -1, 0, "decerr grant");
    tbl[11] = mk(3'b100, 0, 0, 32'h3000_0000, 3'b000, 7'h01, 7'h00, 7'h00, 0, 2, -1, 0, "decerr ar");
    tbl[12] = mk(3'b000, 0, 0, 0, 3'b100, 7'h00, 7'h01, 7'h01, -1, 0, -1, 0, "decerr last");
    // Inclusive upper limit of S6.
    tbl[13] = mk(3'b010, 0, 32'h201F_FFFF, 0, 3'b000, 7'h00, 7'h00, 7'h00, 6, 1, -1, 0, "s6 limit grant");
    tbl[14] = mk(3'b010, 0, 32'h201F_FFFF, 0, 3'b000, 7'h40, 7'h00, 7'h00, 6, 1, -1, 0, "s6 limit ar");
    tbl[15] = mk(3'b000, 0, 0, 0, 3'b010, 7'h00, 7'h40, 7'h40, -1, 0, -1, 0, "s6 limit last");
    // One past S4 limit falls to slot 0.
    tbl[16] = mk(3'b001, 32'h1000_0400, 0, 0, 3'b000, 7'h00, 7'h00, 7'h00, 0, 0, -1, 0, "s4 past grant");
    tbl[17] = mk(3'b001, 32'h1000_0400, 0, 0, 3'b000, 7'h01, 7'h00, 7'h00, 0, 0, -1, 0, "s4 past ar");
    tbl[18] = mk(3'b000, 0, 0, 0, 3'b001, 7'h00, 7'h01, 7'h01, -1, 0, -1, 0, "s4 past last");
    // S3 last address and the one after it, in parallel.
    tbl[19] = mk(3'b110, 0, 32'h0002_FFFF, 32'h0003_0000, 3'b000, 7'h00, 7'h00, 7'h00, 3, 1, 0, 2, "s3 edge grant");
    tbl[20] = mk(3'b110, 0, 32'h0002_FFFF, 32'h0003_0000, 3'b000, 7'h09, 7'h00, 7'h00, 3, 1, 0, 2, "s3 edge ar");
    tbl[21] = mk(3'b000, 0, 0, 0, 3'b110, 7'h00, 7'h09, 7'h09, -1, 0, -1, 0, "s3 edge last");

    ARESET = 1'b1;
    ARVALID_M = '0; ARADDR_M = '0; RREADY_M = '0;
    ARREADY_S = '0; RVALID_S = '0; RLAST_S = '0;
    repeat (2) @(posedge ACLK);
    #1;
    check("reset SRIdx", 32'(SRIdx), 32'(C_SR_IDLE));
    check("reset MRIdx", 32'(MRIdx), 32'(C_MR_IDLE));
    ARESET = 1'b0;

    for (int i = 0; i < 22; i++) apply(tbl[i]);

    // Contention on S1: both masters keep requesting.
    apply(mk(3'b011, 32'h100, 32'h100, 0, 3'b000, 7'h00, 7'h00, 7'h00, 1, 0, -1, 0, "cont r1 grant"));
    apply(mk(3'b011, 32'h100, 32'h100, 0, 3'b000, 7'h02, 7'h00, 7'h00, 1, 0, -1, 0, "cont r1 ar"));
    apply(mk(3'b011, 32'h100, 32'h100, 0, 3'b011, 7'h00, 7'h02, 7'h02, -1, 0, -1, 0, "cont r1 last"));
    apply(mk(3'b011, 32'h100, 32'h100, 0, 3'b000, 7'h00, 7'h00, 7'h00, 1, C_R2_WIN, -1, 0, "cont r2 grant"));
    apply(mk(3'b011, 32'h100, 32'h100, 0, 3'b000, 7'h02, 7'h00, 7'h00, 1, C_R2_WIN, -1, 0, "cont r2 ar"));
    apply(mk(3'b011, 32'h100, 32'h100, 0, 3'b011, 7'h00, 7'h02, 7'h02, -1, 0, -1, 0, "cont r2 last"));
    apply(mk(3'b011, 32'h100, 32'h100, 0, 3'b000, 7'h00, 7'h00, 7'h00, 1, 0, -1, 0, "cont r3 grant"));
    apply(mk(3'b001, 32'h100, 32'h100, 0, 3'b000, 7'h02, 7'h00, 7'h00, 1, 0, -1, 0, "cont r3 ar"));
    apply(mk(3'b000, 0, 0, 0, 3'b001, 7'h00, 7'h02, 7'h02, -1, 0, -1, 0, "cont r3 last"));

    // Backpressure on S4: last beat offered while M2 is not ready.
    apply(mk(3'b100, 0, 0, 32'h1000_0000, 3'b000, 7'h00, 7'h00, 7'h00, 4, 2, -1, 0, "bp grant"));
    apply(mk(3'b100, 0, 0, 32'h1000_0000, 3'b000, 7'h10, 7'h00, 7'h00, 4, 2, -1, 0, "bp ar"));
    for (int i = 0; i < 5; i++)
      apply(mk(3'b000, 0, 0, 0, 3'b011, 7'h00, 7'h10, 7'h10, 4, 2, -1, 0, "bp hold"));
    apply(mk(3'b000, 0, 0, 0, 3'b100, 7'h00, 7'h10, 7'h10, -1, 0, -1, 0, "bp release"));

    // Asynchronous reset while a binding is active.
    apply(mk(3'b001, 32'h1001_0000, 0, 0, 3'b000, 7'h00, 7'h00, 7'h00, 5, 0, -1, 0, "pre-reset grant"));
    #3;
    ARESET = 1'b1;
    #1;
    check("async reset SRIdx", 32'(SRIdx), 32'(C_SR_IDLE));
    check("async reset MRIdx", 32'(MRIdx), 32'(C_MR_IDLE));
    ARVALID_M = '0; ARADDR_M = '0;
    @(negedge ACLK);
    ARESET = 1'b0;
    v = mk(3'b000, 0, 0, 0, 3'b000, 7'h00, 7'h00, 7'h00, -1, 0, -1, 0, "post-reset idle");
    apply(v);
    apply(v);
    apply(mk(3'b001, 32'h1001_0000, 0, 0, 3'b000, 7'h00, 7'h00, 7'h00, 5, 0, -1, 0, "post-reset grant"));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
